// File: rtl/rrf_alloc_ctrl_if.sv
// Dispatch <-> RRF allocation controller signal bundle.
// master = dispatch/commit side, slave = allocation controller.
interface rrf_alloc_ctrl_if #(
   parameter int RRF_SEL = 6
);
   // reqN_i is a request held for the cycle; alloc_enN_o is the same-cycle
   // grant. A request is consumed only on a cycle where its grant is high.
   logic               req1_i;
   logic               req2_i;
   logic               stall_dp_i;
   logic               com1_en_i;
   logic               com2_en_i;
   logic               flush_i;
   logic               alloc_en1_o;
   logic               alloc_en2_o;
   logic [RRF_SEL-1:0] rrftag1_o;
   logic [RRF_SEL-1:0] rrftag2_o;
   logic               allocatable_o;
   logic [RRF_SEL:0]   freenum_o;
   logic [RRF_SEL-1:0] rrfptr_o;
   logic [RRF_SEL-1:0] comptr_o;
   logic               nextrrfcyc_o;
   logic               err_o;

   modport master (
      output req1_i, req2_i, stall_dp_i, com1_en_i, com2_en_i, flush_i,
      input  alloc_en1_o, alloc_en2_o, rrftag1_o, rrftag2_o, allocatable_o,
             freenum_o, rrfptr_o, comptr_o, nextrrfcyc_o, err_o
   );

   modport slave (
      input  req1_i, req2_i, stall_dp_i, com1_en_i, com2_en_i, flush_i,
      output alloc_en1_o, alloc_en2_o, rrftag1_o, rrftag2_o, allocatable_o,
             freenum_o, rrfptr_o, comptr_o, nextrrfcyc_o, err_o
   );
endinterface

// File: rtl/rrf_alloc_ctrl.sv
// Rename register file allocation controller: circular-buffer tag issue,
// in-order commit reclaim, mispredict flush and protocol-violation flag.
module rrf_alloc_ctrl #(
   parameter int RRF_NUM = 64,
   parameter int RRF_SEL = 6
) (
   input logic             clk,
   input logic             reset,
   rrf_alloc_ctrl_if.slave bus
);
   localparam logic [RRF_SEL:0]   NUM_W  = (RRF_SEL+1)'(RRF_NUM);
   localparam logic [RRF_SEL+1:0] NUM_WX = (RRF_SEL+2)'(RRF_NUM);

   // Pointers carry one extra MSB: the wrap parity of that pointer.
   logic [RRF_SEL:0]   rrfptr_q, comptr_q, freenum_q;
   logic               err_q;

   logic [1:0]         reqnum, comnum;
   logic [RRF_SEL:0]   reqnum_w, comnum_w, occupied, com_eff, alloc_num;
   logic [RRF_SEL+1:0] free_sum;
   logic               allocatable, do_alloc, com_ovf, free_ovf, com_order_bad, viol;
   logic [RRF_SEL:0]   comptr_nxt, rrfptr_nxt, freenum_nxt;

   always_comb begin
      reqnum   = {1'b0, bus.req1_i} + {1'b0, bus.req2_i};
      comnum   = {1'b0, bus.com1_en_i} + {1'b0, bus.com2_en_i};
      reqnum_w = (RRF_SEL+1)'(reqnum);
      comnum_w = (RRF_SEL+1)'(comnum);
      occupied = NUM_W - freenum_q;

      // Only registered free count is used, so same-cycle commits never
      // enable a same-cycle allocation. No partial grants.
      allocatable = (freenum_q >= reqnum_w);
      do_alloc    = allocatable & ~bus.stall_dp_i & ~bus.flush_i;
      alloc_num   = do_alloc ? reqnum_w : '0;

      com_order_bad = bus.com2_en_i & ~bus.com1_en_i;
      com_ovf       = (comnum_w > occupied);
      com_eff       = com_ovf ? occupied : comnum_w;

      free_sum = {1'b0, freenum_q} + {1'b0, com_eff} - {1'b0, alloc_num};
      free_ovf = (free_sum > NUM_WX);
      viol     = com_order_bad | com_ovf | free_ovf;

      comptr_nxt = comptr_q + com_eff;
      if (bus.flush_i) begin
         rrfptr_nxt  = comptr_nxt;
         freenum_nxt = NUM_W;
      end else begin
         rrfptr_nxt  = rrfptr_q + alloc_num;
         freenum_nxt = free_ovf ? NUM_W : free_sum[RRF_SEL:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rrfptr_q  <= '0;
         comptr_q  <= '0;
         freenum_q <= NUM_W;
         err_q     <= 1'b0;
      end else begin
         rrfptr_q  <= rrfptr_nxt;
         comptr_q  <= comptr_nxt;
         freenum_q <= freenum_nxt;
         err_q     <= err_q | viol;
      end
   end

   assign bus.allocatable_o = allocatable;
   assign bus.alloc_en1_o   = do_alloc & bus.req1_i;
   assign bus.alloc_en2_o   = do_alloc & bus.req2_i;
   assign bus.rrftag1_o     = rrfptr_q[RRF_SEL-1:0];
   assign bus.rrftag2_o     = bus.req1_i ? rrfptr_q[RRF_SEL-1:0] + 1'b1
                                         : rrfptr_q[RRF_SEL-1:0];
   assign bus.freenum_o     = freenum_q;
   assign bus.rrfptr_o      = rrfptr_q[RRF_SEL-1:0];
   assign bus.comptr_o      = comptr_q[RRF_SEL-1:0];
   assign bus.nextrrfcyc_o  = rrfptr_q[RRF_SEL];
   assign bus.err_o         = err_q;
endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Self-checking bench for rrf_alloc_ctrl with a reference model and an
// expected-state queue.
module tb_rrf_alloc_ctrl;
   logic clk;
   logic reset;

   rrf_alloc_ctrl_if #(.RRF_SEL(6)) bus ();

   rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference state: pointers as 0..127 (bit 6 is wrap parity).
   int m_rrf, m_com, m_free;
   logic m_err;

   logic [20:0] exp_q[$];
   logic last_a1, last_a2;
   logic [5:0] last_t1, last_t2;

   task automatic step(input logic rst, input logic r1, input logic r2, input logic st,
                       input logic c1, input logic c2, input logic fl);
      int reqn, comn, occ, ce, an;
      logic allow, grant;
      logic [14:0] exp_c, got_c;
      logic [20:0] exp_s, got_s;
      @(negedge clk);
      reset = rst; bus.req1_i = r1; bus.req2_i = r2; bus.stall_dp_i = st;
      bus.com1_en_i = c1; bus.com2_en_i = c2; bus.flush_i = fl;
      #1;
      reqn  = int'(r1) + int'(r2);
      comn  = int'(c1) + int'(c2);
      allow = (m_free >= reqn);
      grant = allow && !st && !fl;
      exp_c = {grant & r1, grant & r2, 6'(m_rrf), (r1 ? 6'(m_rrf + 1) : 6'(m_rrf)), allow};
      got_c = {bus.alloc_en1_o, bus.alloc_en2_o, bus.rrftag1_o, bus.rrftag2_o, bus.allocatable_o};
      last_a1 = bus.alloc_en1_o; last_a2 = bus.alloc_en2_o;
      last_t1 = bus.rrftag1_o;   last_t2 = bus.rrftag2_o;
      vec_cnt++;
      if (got_c !== exp_c) begin
         err_cnt++;
         $display("FAIL comb {en1,en2,tag1,tag2,allocatable}: got %b required %b", got_c, exp_c);
      end
      // Advance the model.
      if (rst) begin
         m_rrf = 0; m_com = 0; m_free = 64; m_err = 1'b0;
      end else begin
         occ = 64 - m_free;
         ce  = (comn > occ) ? occ : comn;
         if ((c2 && !c1) || comn > occ) m_err = 1'b1;
         m_com = (m_com + ce) % 128;
         if (fl) begin
            m_rrf  = m_com;
            m_free = 64;
         end else begin
            an     = grant ? reqn : 0;
            m_rrf  = (m_rrf + an) % 128;
            m_free = m_free + ce - an;
            if (m_free > 64) begin m_free = 64; m_err = 1'b1; end
         end
      end
      exp_q.push_back({m_err, 1'(m_rrf >> 6), 7'(m_free), 6'(m_com), 6'(m_rrf)});
      @(posedge clk);
      #1;
      got_s = {bus.err_o, bus.nextrrfcyc_o, bus.freenum_o, bus.comptr_o, bus.rrfptr_o};
      exp_s = exp_q.pop_front();
      vec_cnt++;
      if (got_s !== exp_s) begin
         err_cnt++;
         $display("FAIL state {err,cyc,freenum,comptr,rrfptr}: got %0b/%0b/%0d/%0d/%0d required %0b/%0b/%0d/%0d/%0d",
                  got_s[20], got_s[19], got_s[18:12], got_s[11:6], got_s[5:0],
                  exp_s[20], exp_s[19], exp_s[18:12], exp_s[11:6], exp_s[5:0]);
      end
   endtask

   task automatic check_val(input string name, input int got, input int req);
      vec_cnt++;
      if (got !== req) begin
         err_cnt++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      step(1, 1, 1, 0, 1, 1, 1);
      check_val("reset_freenum", int'(bus.freenum_o), 64);
      check_val("reset_rrfptr", int'(bus.rrfptr_o), 0);
      check_val("reset_err", int'(bus.err_o), 0);
   endtask

   task automatic test_dual_alloc();
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      check_val("dual_tags0", {26'd0, last_t1, last_t2}, {6'd0, 6'd1});
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      check_val("dual_tags2", {26'd0, last_t1, last_t2}, {6'd4, 6'd5});
      check_val("dual_freenum", int'(bus.freenum_o), 58);
      check_val("dual_rrfptr", int'(bus.rrfptr_o), 6);
   endtask

   task automatic test_fill();
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 28; i++) step(0, 1, 1, 0, 0, 0, 0);
      check_val("fill_freenum1", int'(bus.freenum_o), 1);
      step(0, 1, 1, 0, 0, 0, 0);
      check_val("fill_no_partial", int'({last_a1, last_a2}), 0);
      step(0, 0, 1, 0, 0, 0, 0);
      check_val("fill_slot2_grant", int'(last_a2), 1);
      check_val("fill_slot2_tag", int'(last_t2), 63);
      check_val("fill_freenum0", int'(bus.freenum_o), 0);
      check_val("fill_cyc_toggle", int'(bus.nextrrfcyc_o), 1);
   endtask

   task automatic test_full_commit();
      step(0, 1, 1, 0, 1, 1, 0);
      check_val("full_commit_nogrant", int'({last_a1, last_a2}), 0);
      check_val("full_commit_freenum", int'(bus.freenum_o), 2);
      step(0, 1, 1, 0, 0, 0, 0);
      check_val("full_commit_grant", int'({last_a1, last_a2}), 3);
   endtask

   task automatic test_stall();
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 0);
      check_val("stall_nogrant", int'({last_a1, last_a2}), 0);
      step(0, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_flush();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 31; i++) step(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)  step(0, 0, 0, 0, 1, 1, 0);
      check_val("flush_pre_rrfptr", int'(bus.rrfptr_o), 62);
      check_val("flush_pre_comptr", int'(bus.comptr_o), 10);
      step(0, 1, 1, 0, 1, 0, 1);
      check_val("flush_nogrant", int'({last_a1, last_a2}), 0);
      check_val("flush_comptr", int'(bus.comptr_o), 11);
      check_val("flush_rrfptr", int'(bus.rrfptr_o), 11);
      check_val("flush_freenum", int'(bus.freenum_o), 64);
   endtask

   task automatic test_err();
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      check_val("err_set", int'(bus.err_o), 1);
      check_val("err_freenum", int'(bus.freenum_o), 64);
      check_val("err_comptr", int'(bus.comptr_o), 0);
      for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1), 0, 0, 0, 0, 0);
      check_val("err_sticky", int'(bus.err_o), 1);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check_val("err_com2_only", int'(bus.err_o), 1);
   endtask

   task automatic test_back_to_back();
      int toggles;
      logic prev_cyc;
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      toggles  = 0;
      prev_cyc = bus.nextrrfcyc_o;
      for (int i = 0; i < 100; i++) begin
         step(0, 1, 1, 0, 1, 1, 0);
         if (bus.nextrrfcyc_o !== prev_cyc) toggles++;
         prev_cyc = bus.nextrrfcyc_o;
      end
      check_val("b2b_freenum", int'(bus.freenum_o), 60);
      check_val("b2b_toggles", toggles, 3);
      // comptr has advanced 200 entries: parity 1, tag 8.
      step(0, 0, 0, 0, 0, 0, 1);
      check_val("b2b_flush_rrfptr", int'(bus.rrfptr_o), 8);
      check_val("b2b_flush_cyc", int'(bus.nextrrfcyc_o), 1);
      for (int i = 0; i < 6; i++)
         step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0);
      step(1, 1, 1, 0, 1, 1, 1);
      check_val("midreset_freenum", int'(bus.freenum_o), 64);
      check_val("midreset_cyc", int'(bus.nextrrfcyc_o), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.req1_i = 0; bus.req2_i = 0; bus.stall_dp_i = 0;
      bus.com1_en_i = 0; bus.com2_en_i = 0; bus.flush_i = 0;
      m_rrf = 0; m_com = 0; m_free = 64; m_err = 1'b0;
      test_reset();
      test_dual_alloc();
      test_fill();
      test_full_commit();
      test_stall();
      test_flush();
      test_err();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/rrf_alloc_ctrl.md
# rrf_alloc_ctrl

Allocation controller for the rename register file in the dispatch stage. Treats the RRF as a circular buffer. Issues up to two destination rrftags per cycle in program order and reclaims up to two entries per cycle as instructions commit. On a branch mispredict flush it squashes every in-flight allocation. It drives the RRF allocate/invalidate ports and the dispatch stall condition.

## Interface
Parameters:
- RRF_NUM, 64: number of RRF entries; must be a power of two.
- RRF_SEL, 6: tag width, equal to log2(RRF_NUM).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req1_i  in  1  dispatch slot 1 needs a destination tag.
- req2_i  in  1  dispatch slot 2 needs a destination tag.
- stall_dp_i  in  1  downstream stall; no allocation this cycle.
- com1_en_i  in  1  oldest in-flight entry commits.
- com2_en_i  in  1  second-oldest entry commits; only legal together with com1_en_i.
- flush_i  in  1  mispredict; squash all uncommitted allocations.
- alloc_en1_o  out  1  slot 1 tag granted this cycle.
- alloc_en2_o  out  1  slot 2 tag granted this cycle.
- rrftag1_o  out  RRF_SEL  tag for slot 1.
- rrftag2_o  out  RRF_SEL  tag for slot 2.
- allocatable_o  out  1  enough free entries for the current request.
- freenum_o  out  RRF_SEL+1  free-entry count.
- rrfptr_o  out  RRF_SEL  next tag to allocate.
- comptr_o  out  RRF_SEL  oldest uncommitted tag.
- nextrrfcyc_o  out  1  wrap parity of rrfptr; used for age compares.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- Counts: reqnum = req1_i + req2_i (0..2). comnum = com1_en_i + com2_en_i (0..2).
- allocatable_o = (freenum >= reqnum). Combinational.
- Grant condition: do_alloc = allocatable_o & ~stall_dp_i & ~flush_i.
  - alloc_en1_o = do_alloc & req1_i.
  - alloc_en2_o = do_alloc & req2_i.
- Tag assignment:
  - rrftag1_o = rrfptr.
  - rrftag2_o = rrfptr+1 when req1_i; otherwise rrftag2_o = rrfptr.
  - Both tag outputs are driven whether or not a grant happens.
- All pointer arithmetic is modulo RRF_NUM (natural RRF_SEL-bit wrap).
- Per-cycle register update, highest priority first:
  - reset: rrfptr=0, comptr=0, freenum=RRF_NUM, nextrrfcyc=0, err=0.
  - flush_i:
    - comptr += comnum; same-cycle commits are still honoured.
    - rrfptr = the new comptr value.
    - freenum = RRF_NUM.
    - nextrrfcyc = the wrap parity of the new comptr. This requires a comptr parity bit, maintained internally.
    - No allocation in the flush cycle.
  - Otherwise:
    - rrfptr += (do_alloc ? reqnum : 0).
    - comptr += comnum.
    - freenum = freenum + comnum − (do_alloc ? reqnum : 0).
    - nextrrfcyc toggles when rrfptr crosses RRF_NUM−1 → 0.
- Illegal-input detection:
  - Violations: com2_en_i without com1_en_i; comnum greater than the occupied count (RRF_NUM − freenum); freenum computing above RRF_NUM.
  - On any violation, set err_o; it stays high until reset.
  - State still updates with the values saturated: freenum clamped to RRF_NUM, comptr advanced by at most the occupied count.
- Partial grants are not allowed. With reqnum=2 and freenum=1, neither slot is granted.

## Timing
- Grants and tags are combinational from the request inputs and current state, so the RRF invalidates valid bits at the same clock edge.
- Pointer and count outputs are registered and reflect the edge after the event.
- Latency:
  - A tag freed by commit in cycle N can be allocated in cycle N+1.
  - A commit does not contribute free entries to the same cycle's allocatable_o.
- Full: freenum=0 → allocatable_o=0 for any reqnum>0. allocatable_o=1 when reqnum=0.
- Empty: freenum=RRF_NUM with comnum>0 → err_o=1 from the next cycle; freenum stays RRF_NUM.
- Wrap: rrfptr=RRF_NUM−1 with a dual grant gives tags RRF_NUM−1 and 0, and nextrrfcyc toggles.
- Reset asserted mid-stream overrides flush, commit and allocation in the same cycle. All outputs return to their reset values at the next edge.

## Test plan
- Reset, then req1=req2=1 for 3 cycles, RRF_NUM=64 → tags (0,1),(2,3),(4,5); freenum_o 64→62→60→58; rrfptr_o=6.
- Fill to freenum=1 with req1=req2=1 → allocatable_o=0, no grants. Drop to req2 only → alloc_en2_o=1, rrftag2_o=63, freenum_o=0, nextrrfcyc_o toggles to 1.
- freenum=0, com1=com2=1 with a dual request in the same cycle → no grant that cycle; next cycle freenum_o=2 and the dual grant succeeds.
- rrfptr=62, comptr=10, flush_i with com1_en_i=1 → next cycle comptr_o=rrfptr_o=11, freenum_o=64; alloc_en outputs are 0 during the flush cycle.
- Idle reset state, com1_en_i=1 → err_o=1 and stays high; freenum_o=64, comptr_o=0.
- Continuous dual allocate plus dual commit for 100 cycles → freenum_o constant, tags strictly sequential mod 64, nextrrfcyc_o toggles every 32 cycles.
